// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-detection and mult/div handshake bundle between the pipeline datapath
// and the stall/flush controller.
interface pipe_stall_ctrl_if;
  logic [4:0] D_A1;
  logic [4:0] D_A2;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic       D_md_use;
  logic [4:0] E_WR;
  logic       E_RegWrite;
  logic [2:0] E_Tnew;
  logic [4:0] M_WR;
  logic       M_RegWrite;
  logic [2:0] M_Tnew;
  logic       E_md_start;
  logic       E_md_op;
  logic       stall;
  logic       PC_en;
  logic       FD_en;
  logic       DE_clr;
  logic       md_busy;
  logic [3:0] md_cnt;
  logic       md_done;

  modport slave (
    input  D_A1, D_A2, D_Tuse_rs, D_Tuse_rt, D_md_use,
    input  E_WR, E_RegWrite, E_Tnew, M_WR, M_RegWrite, M_Tnew,
    input  E_md_start, E_md_op,
    output stall, PC_en, FD_en, DE_clr, md_busy, md_cnt, md_done
  );

  modport master (
    output D_A1, D_A2, D_Tuse_rs, D_Tuse_rt, D_md_use,
    output E_WR, E_RegWrite, E_Tnew, M_WR, M_RegWrite, M_Tnew,
    output E_md_start, E_md_op,
    input  stall, PC_en, FD_en, DE_clr, md_busy, md_cnt, md_done
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Tuse/Tnew stall controller for the 5-stage pipeline, plus the busy sequencer
// of the multicycle mult/div unit.
module pipe_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stall_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e  state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_done_q, md_done_d;

  logic stall_rs_s;
  logic stall_rt_s;
  logic stall_md_s;
  logic stall_s;

  // A read stalls when its producer delivers later than the reader needs it; $0 never hazards.
  function automatic logic read_hazard(
    input logic [4:0] a,
    input logic [1:0] tuse,
    input logic [4:0] e_wr,
    input logic       e_we,
    input logic [2:0] e_tnew,
    input logic [4:0] m_wr,
    input logic       m_we,
    input logic [2:0] m_tnew
  );
    logic [2:0] tuse_x;
    logic       e_hit;
    logic       m_hit;
    tuse_x = {1'b0, tuse};
    e_hit  = e_we && (e_wr == a) && (e_tnew > tuse_x);
    m_hit  = m_we && (m_wr == a) && (m_tnew > tuse_x);
    return (a != 5'd0) && (tuse != 2'd3) && (e_hit || m_hit);
  endfunction

  // Combinational hazard detection and pipeline register controls
  always_comb begin
    stall_rs_s = read_hazard(bus.D_A1, bus.D_Tuse_rs, bus.E_WR, bus.E_RegWrite,
                             bus.E_Tnew, bus.M_WR, bus.M_RegWrite, bus.M_Tnew);
    stall_rt_s = read_hazard(bus.D_A2, bus.D_Tuse_rt, bus.E_WR, bus.E_RegWrite,
                             bus.E_Tnew, bus.M_WR, bus.M_RegWrite, bus.M_Tnew);
    stall_md_s = bus.D_md_use && ((state_q == BUSY) || bus.E_md_start);
    stall_s    = stall_rs_s | stall_rt_s | stall_md_s;
  end

  // Next-state logic for the mult/div busy sequencer
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    md_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.E_md_start) begin
          state_d  = BUSY;
          md_cnt_d = bus.E_md_op ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d  = IDLE;
          md_cnt_d = 4'd0;
        end
      end
      BUSY: begin
        // A start arriving while busy is illegal and deliberately ignored.
        if (md_cnt_q == 4'd1) begin
          state_d   = IDLE;
          md_cnt_d  = 4'd0;
          md_done_d = 1'b1;
        end else begin
          state_d  = BUSY;
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = 4'd0;
      end
    endcase
  end

  // Sequencer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      md_cnt_q  <= 4'd0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      md_done_q <= md_done_d;
    end
  end

  assign bus.stall   = stall_s;
  assign bus.PC_en   = ~stall_s;
  assign bus.FD_en   = ~stall_s;
  assign bus.DE_clr  = stall_s;
  assign bus.md_busy = (state_q == BUSY);
  assign bus.md_cnt  = md_cnt_q;
  assign bus.md_done = md_done_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and randomized bench for pipe_stall_ctrl against a cycle-indexed
// reference model of the hazard rules and mult/div timing.
module tb_pipe_stall_ctrl;

  logic clk;
  logic reset;
  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cyc;
  int op_start;
  int op_len;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reader needs the value in tuse cycles, producer has it in tnew cycles.
  function automatic logic ref_hazard(input logic [4:0] a, input logic [1:0] tuse);
    int need;
    logic hit;
    need = int'(tuse);
    hit  = 1'b0;
    if (a != 5'd0 && need != 3) begin
      if (bus.E_RegWrite && bus.E_WR == a && int'(bus.E_Tnew) > need) hit = 1'b1;
      if (bus.M_RegWrite && bus.M_WR == a && int'(bus.M_Tnew) > need) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic cycle(input int exp_stall);
    logic m_busy;
    logic m_done;
    logic [3:0] m_cnt;
    logic m_stall;
    @(negedge clk);
    m_busy  = (cyc > op_start) && (cyc <= op_start + op_len);
    m_cnt   = m_busy ? 4'(op_start + op_len + 1 - cyc) : 4'd0;
    m_done  = (cyc == op_start + op_len + 1);
    m_stall = ref_hazard(bus.D_A1, bus.D_Tuse_rs) | ref_hazard(bus.D_A2, bus.D_Tuse_rt) |
              (bus.D_md_use && (m_busy || bus.E_md_start));
    check("stall",   {3'd0, bus.stall},   {3'd0, m_stall});
    check("PC_en",   {3'd0, bus.PC_en},   {3'd0, ~m_stall});
    check("FD_en",   {3'd0, bus.FD_en},   {3'd0, ~m_stall});
    check("DE_clr",  {3'd0, bus.DE_clr},  {3'd0, m_stall});
    check("md_busy", {3'd0, bus.md_busy}, {3'd0, m_busy});
    check("md_cnt",  bus.md_cnt,          m_cnt);
    check("md_done", {3'd0, bus.md_done}, {3'd0, m_done});
    if (exp_stall >= 0) check("stall_directed", {3'd0, bus.stall}, 4'(exp_stall));
    if (reset) begin
      op_start = -1000;
    end else if (bus.E_md_start && !m_busy) begin
      op_start = cyc;
      op_len   = bus.E_md_op ? 10 : 5;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.D_A1 = 5'd0;       bus.D_A2 = 5'd0;
    bus.D_Tuse_rs = 2'd3;  bus.D_Tuse_rt = 2'd3;
    bus.D_md_use = 1'b0;
    bus.E_WR = 5'd0;       bus.E_RegWrite = 1'b0;  bus.E_Tnew = 3'd0;
    bus.M_WR = 5'd0;       bus.M_RegWrite = 1'b0;  bus.M_Tnew = 3'd0;
    bus.E_md_start = 1'b0; bus.E_md_op = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    op_start = -1000; op_len = 0;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    cycle(0);
    reset = 1'b0;
    cycle(0);

    // load-use on rs
    bus.E_WR = 5'd5; bus.E_RegWrite = 1'b1; bus.E_Tnew = 3'd2;
    bus.D_A1 = 5'd5; bus.D_Tuse_rs = 2'd0;
    cycle(1);
    bus.D_Tuse_rs = 2'd3;
    cycle(0);

    // M-stage hazard on rt
    idle_inputs();
    bus.M_WR = 5'd8; bus.M_RegWrite = 1'b1; bus.M_Tnew = 3'd1; bus.D_A2 = 5'd8;
    bus.D_Tuse_rt = 2'd1; cycle(0);
    bus.D_Tuse_rt = 2'd0; cycle(1);
    bus.M_RegWrite = 1'b0; cycle(0);

    // writes to $0 never stall
    idle_inputs();
    bus.E_WR = 5'd0; bus.E_Tnew = 3'd2; bus.E_RegWrite = 1'b1;
    bus.D_A1 = 5'd0; bus.D_Tuse_rs = 2'd0;
    cycle(0);

    // mult sequencing with D_md_use held
    idle_inputs();
    bus.D_md_use = 1'b1;
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b0;
    cycle(1);
    bus.E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1);
    cycle(0);
    cycle(0);

    // div sequencing with an ignored second start
    idle_inputs();
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b1;
    cycle(0);
    bus.E_md_start = 1'b0;
    for (int i = 0; i < 3; i++) cycle(0);
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b0;
    cycle(0);
    bus.E_md_start = 1'b0;
    for (int i = 0; i < 8; i++) cycle(0);

    // reset on the third busy cycle of a div
    bus.E_md_start = 1'b1; bus.E_md_op = 1'b1;
    cycle(0);
    bus.E_md_start = 1'b0;
    cycle(0);
    cycle(0);
    reset = 1'b1;
    cycle(0);
    reset = 1'b0;
    bus.D_md_use = 1'b1;
    for (int i = 0; i < 13; i++) cycle(0);

    // start on the same cycle as reset is dropped by reset
    idle_inputs();
    reset = 1'b1; bus.E_md_start = 1'b1;
    cycle(-1);
    reset = 1'b0; bus.E_md_start = 1'b0;
    cycle(-1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 59) == 0);
      bus.D_A1       = 5'($urandom_range(0, 3));
      bus.D_A2       = 5'($urandom_range(0, 3));
      bus.D_Tuse_rs  = 2'($urandom_range(0, 3));
      bus.D_Tuse_rt  = 2'($urandom_range(0, 3));
      bus.D_md_use   = 1'($urandom_range(0, 1));
      bus.E_WR       = 5'($urandom_range(0, 3));
      bus.E_RegWrite = 1'($urandom_range(0, 1));
      bus.E_Tnew     = 3'($urandom_range(0, 3));
      bus.M_WR       = 5'($urandom_range(0, 3));
      bus.M_RegWrite = 1'($urandom_range(0, 1));
      bus.M_Tnew     = 3'($urandom_range(0, 2));
      bus.E_md_start = ($urandom_range(0, 7) == 0);
      bus.E_md_op    = 1'($urandom_range(0, 1));
      cycle(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
